fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, clocked in the read domain. It pops 8-bit entries from the FIFO read port and packs them little-endian into 32-bit words. It presents those words on a valid/ready output interface with a single-entry output slot. A flush request emits any partially filled word, tagged with a byte-enable mask and a last marker.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO entry.
- `BYTES_PER_WORD`, 4, FIFO entries per output word (≥2).
- `rclk`  in  1  read-domain clock, rising edge.
- `rrst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag (read domain).
- `fifo_r_en`  out  1  FIFO pop request.
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop.
- `flush`  in  1  one-cycle pulse requesting emission of the partial word.
- `flush_done`  out  1  one-cycle pulse when the flush completes.
- `m_data`  out  DATA_WIDTH*BYTES_PER_WORD  packed word; byte 0 is the earliest popped byte, in bits [7:0].
- `m_keep`  out  BYTES_PER_WORD  byte-valid mask.
- `m_last`  out  1  marks the word emitted by a flush.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.

## Operation
- Internal state: accumulator `acc`, byte count `cnt` (0..BYTES_PER_WORD), pop-in-flight bit `infl`, and the output slot.
- Pop rule: `fifo_r_en` = `!fifo_empty && state==RUN && (cnt+infl) < BYTES_PER_WORD`.
  - `fifo_r_en` is never high while `fifo_empty` is high.
- Capture: when `infl` is set, `fifo_data_out` is written into byte lane `cnt`, and `cnt` increments.
- Word completion: when `cnt` reaches BYTES_PER_WORD, `acc` moves into the output slot if the slot is empty or being accepted that cycle. The transfer sets `m_keep`=all ones and `m_last`=0, and clears `cnt`/`acc`. Otherwise `acc` holds and pops stall.
- The output slot holds `m_data`/`m_keep`/`m_last` stable while `m_valid && !m_ready`.
- FSM states:
  - RUN: normal operation. `flush` → FLUSH_WAIT.
  - FLUSH_WAIT: no new pops; wait for `infl`=0 to land. Then:
    - `cnt`==0 → RUN, pulse `flush_done`, emit nothing.
    - otherwise → FLUSH_EMIT.
  - FLUSH_EMIT: when the slot is free, load `acc` zero-padded, `m_keep`=(1<<cnt)-1, `m_last`=1. Clear `cnt`, pulse `flush_done`, → RUN.
- `flush` while not in RUN is ignored.
- A full word completing during FLUSH_WAIT is emitted as a normal word. The flush then finds `cnt`=0.
- Reset values: `fifo_r_en`=0, `flush_done`=0, `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0. Internal `cnt`=0, `infl`=0, state RUN.
- Reset mid-operation: in-flight and accumulated bytes are discarded.

## Timing
- Pop issued in cycle t → byte captured at the edge ending cycle t+1.
- The 4th byte captured at edge E → `m_valid` high immediately after E.
- Pops in cycles 0,1,2,3 → no pop in cycle 4 → `m_valid` high in cycle 5, with pops resuming in cycle 5.
- Steady state with `m_ready`=1: four pops per five cycles.
- `m_ready` low: at most one complete word in the slot plus one in `acc`; pops stop.
- Flush with `infl`=0 and the slot free: `flush` in cycle t → FLUSH_WAIT in t+1 → partial word `m_valid` and `flush_done` in t+3.

## Configuration
- `FIFO_RD_PACKER_STATS_EN` defined: adds output `word_count` [15:0]. It resets to 0, increments on each `m_valid && m_ready`, and wraps at 65535→0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `fifo_rd_pkg`: state enum `rd_pack_state_t` {RUN, FLUSH_WAIT, FLUSH_EMIT}, and the default `DATA_WIDTH`/`BYTES_PER_WORD` constants.
- Sub-module `fifo_rd_out_slot`: single-entry valid/ready holding register for data/keep/last, with a `slot_free` indication back to the packer.

## Test plan
- Reset mid-word:
  - Reset during operation → all outputs 0.
  - Bytes 0xAA,0xBB from before reset never appear.
  - The first post-reset word contains only post-reset bytes.
- Streaming: FIFO holds 0x00..0x07, `m_ready`=1 → words 0x03020100 then 0x07060504, `m_keep`=4'hF, `m_last`=0.
  - The first `m_valid` comes 5 cycles after the first pop.
- Backpressure: `m_ready`=0 with 12 bytes available.
  - Exactly 8 bytes are popped, then `fifo_r_en` stays 0.
  - `m_data`=0x03020100 stays stable.
  - Releasing `m_ready` → remaining words arrive in order.
- Flush partial: 3 bytes 0x11,0x22,0x33 then `flush` → `m_data`=0x00332211, `m_keep`=4'b0111, `m_last`=1, `flush_done` pulses once.
- Empty handling:
  - `fifo_empty` high → `fifo_r_en` never asserted.
  - `flush` with `cnt`=0 → `flush_done` pulses 2 cycles later and no word is emitted.
- Stats (macro defined): 65537 accepted words → `word_count`=1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared FSM state type and default geometry for the FIFO read-side packer.
package fifo_rd_pkg;

   localparam int DEFAULT_DATA_WIDTH     = 8;
   localparam int DEFAULT_BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FLUSH_WAIT = 2'd1,
      FLUSH_EMIT = 2'd2
   } rd_pack_state_t;

endpackage

// File: rtl/fifo_rd_out_slot.sv
// fifo_rd_out_slot: single-entry valid/ready holding register for packed words,
// reporting slot_free when a new word may be loaded this cycle.
module fifo_rd_out_slot
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_DATA_WIDTH * DEFAULT_BYTES_PER_WORD,
   parameter int KEEP_W = DEFAULT_BYTES_PER_WORD
) (
   input  logic              rclk,
   input  logic              rrst,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_data,
   input  logic [KEEP_W-1:0] load_keep,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [WIDTH-1:0]  data,
   output logic [KEEP_W-1:0] keep,
   output logic              last,
   output logic              slot_free
);

   // A word being accepted this cycle frees the slot for a same-cycle reload.
   assign slot_free = !valid || ready;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         valid <= 1'b0;
         data  <= '0;
         keep  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         keep  <= load_keep;
         last  <= load_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO entries and packs them little-endian into words on a valid/ready
// stream, with flush of partial words. Define FIFO_RD_PACKER_STATS_EN to add word_count.
module fifo_rd_packer
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD
) (
   input  logic                                 rclk,
   input  logic                                 rrst,
   input  logic                                 fifo_empty,
   output logic                                 fifo_r_en,
   input  logic [DATA_WIDTH-1:0]                fifo_data_out,
   input  logic                                 flush,
   output logic                                 flush_done,
   output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] m_data,
   output logic [BYTES_PER_WORD-1:0]            m_keep,
   output logic                                 m_last,
   output logic                                 m_valid,
   input  logic                                 m_ready
`ifdef FIFO_RD_PACKER_STATS_EN
   ,
   output logic [15:0]                          word_count
`endif
);

   localparam int               CNT_W  = $clog2(BYTES_PER_WORD + 1);
   localparam int               LANE_W = $clog2(BYTES_PER_WORD);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(BYTES_PER_WORD);

   rd_pack_state_t state, state_nxt;

   logic [CNT_W-1:0]                          cnt, cnt_cap;
   logic [CNT_W:0]                            occupancy;
   logic [LANE_W-1:0]                         lane;
   logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] acc, acc_cap, load_data;
   logic [BYTES_PER_WORD-1:0]                 part_keep, load_keep;
   logic                                      infl;
   logic                                      slot_free;
   logic                                      word_done;
   logic                                      emit_flush;
   logic                                      done_nxt;
   logic                                      load;
   logic                                      load_last;

   // Bytes already held plus the one in flight bound how many more pops fit in acc.
   assign occupancy = {1'b0, cnt} + {{CNT_W{1'b0}}, infl};
   assign fifo_r_en = !rrst && !fifo_empty && (state == RUN) && (occupancy < {1'b0, FULL});

   assign lane    = cnt[LANE_W-1:0];
   assign cnt_cap = cnt + {{(CNT_W-1){1'b0}}, infl};

   always_comb begin
      acc_cap = acc;
      if (infl) acc_cap[lane] = fifo_data_out;
   end

   always_comb begin
      for (int i = 0; i < BYTES_PER_WORD; i++) part_keep[i] = (i < int'(cnt));
   end

   // A word finishing this edge bypasses acc straight into the slot.
   assign word_done = (cnt_cap == FULL) && slot_free;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt  = state;
      emit_flush = 1'b0;
      done_nxt   = 1'b0;
      unique case (state)
         RUN: begin
            if (flush) state_nxt = FLUSH_WAIT;
         end
         FLUSH_WAIT: begin
            if (!infl) begin
               if (cnt == '0) begin
                  state_nxt = RUN;
                  done_nxt  = 1'b1;
               end else if (cnt != FULL) begin
                  state_nxt = FLUSH_EMIT;
               end
            end
         end
         FLUSH_EMIT: begin
            if (slot_free) begin
               emit_flush = 1'b1;
               done_nxt   = 1'b1;
               state_nxt  = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   assign load      = word_done || emit_flush;
   assign load_data = word_done ? acc_cap : acc;
   assign load_keep = word_done ? {BYTES_PER_WORD{1'b1}} : part_keep;
   assign load_last = emit_flush;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state      <= RUN;
         cnt        <= '0;
         acc        <= '0;
         infl       <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so each flop samples pre-edge values of the others.
         state      <= state_nxt;
         infl       <= fifo_r_en;
         flush_done <= done_nxt;
         if (load) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt_cap;
            acc <= acc_cap;
         end
      end
   end

   fifo_rd_out_slot #(
      .WIDTH  (DATA_WIDTH * BYTES_PER_WORD),
      .KEEP_W (BYTES_PER_WORD)
   ) u_slot (
      .rclk      (rclk),
      .rrst      (rrst),
      .load      (load),
      .load_data (load_data),
      .load_keep (load_keep),
      .load_last (load_last),
      .ready     (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .keep      (m_keep),
      .last      (m_last),
      .slot_free (slot_free)
   );

`ifdef FIFO_RD_PACKER_STATS_EN
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) word_count <= '0;
      else if (m_valid && m_ready) word_count <= word_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and randomized checks of fifo_rd_packer against a
// byte-stream scoreboard built from the packing and flush rules.
module tb_fifo_rd_packer;

   localparam int BPW = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic        fifo_r_en;
   logic [7:0]  fifo_data_out = 8'h00;
   logic        flush = 1'b0;
   logic        flush_done;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_last;
   logic        m_valid;
   logic        m_ready = 1'b0;
`ifdef FIFO_RD_PACKER_STATS_EN
   logic [15:0] word_count;
`endif

   fifo_rd_packer #(
      .DATA_WIDTH     (8),
      .BYTES_PER_WORD (BPW)
   ) dut (
      .rclk          (rclk),
      .rrst          (rrst),
      .fifo_empty    (fifo_empty),
      .fifo_r_en     (fifo_r_en),
      .fifo_data_out (fifo_data_out),
      .flush         (flush),
      .flush_done    (flush_done),
      .m_data        (m_data),
      .m_keep        (m_keep),
      .m_last        (m_last),
      .m_valid       (m_valid),
      .m_ready       (m_ready)
`ifdef FIFO_RD_PACKER_STATS_EN
      ,
      .word_count    (word_count)
`endif
   );

   always #5 rclk = ~rclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   // Bench FIFO: data appears the cycle after a pop.
   logic [7:0] fq[$];
   always @(posedge rclk) begin
      if (fifo_r_en && fq.size() > 0) fifo_data_out <= fq.pop_front();
   end

   // Reference model: popped bytes accumulate; every 4 make a word, a flush cuts the remainder.
   logic [7:0]  mq[$];
   logic [7:0]  pend[$];
   word_t       expq[$];
   word_t       got[$];
   word_t       held_w;
   logic        held = 1'b0;
   logic        flush_busy = 1'b0;
   logic        hold_empty = 1'b0;
   logic [15:0] wc_model = '0;
   int cyc = 0, pops = 0, flushes = 0, dones = 0;
   int first_pop_cyc = -1, first_valid_cyc = -1, flush_cyc = -1, done_cyc = -1;

   function automatic word_t cut_pending(input logic last);
      word_t w;
      w.data = '0;
      w.keep = '0;
      w.last = last;
      for (int i = 0; i < pend.size(); i++) begin
         w.data = w.data | (32'(pend[i]) << (8 * i));
         w.keep[i] = 1'b1;
      end
      pend.delete();
      return w;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      fq.push_back(b);
      mq.push_back(b);
   endtask

   task automatic reset_model();
      fq.delete();
      mq.delete();
      pend.delete();
      expq.delete();
      held = 1'b0;
      flush_busy = 1'b0;
      wc_model = '0;
   endtask

   task automatic monitor();
      word_t w, e;
      if (fifo_empty) check("pop_while_empty", fifo_r_en, 1'b0);
      if (rrst) return;
      if (fifo_r_en) begin
         pops++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         if (mq.size() > 0) pend.push_back(mq.pop_front());
         if (pend.size() == BPW) expq.push_back(cut_pending(1'b0));
      end
      if (flush && !flush_busy) begin
         flush_busy = 1'b1;
         flush_cyc  = cyc;
         flushes++;
         if (pend.size() != 0) expq.push_back(cut_pending(1'b1));
      end
      if (flush_done) begin
         check("flush_done_expected", flush_busy, 1'b1);
         flush_busy = 1'b0;
         done_cyc   = cyc;
         dones++;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (held) begin
         check("hold_valid", m_valid, 1'b1);
         check("hold_data", m_data, held_w.data);
         check("hold_keep", m_keep, held_w.keep);
         check("hold_last", m_last, held_w.last);
      end
      held = m_valid && !m_ready;
      held_w.data = m_data;
      held_w.keep = m_keep;
      held_w.last = m_last;
`ifdef FIFO_RD_PACKER_STATS_EN
      check("word_count", word_count, wc_model);
`endif
      if (m_valid && m_ready) begin
         w.data = m_data;
         w.keep = m_keep;
         w.last = m_last;
         got.push_back(w);
         wc_model = wc_model + 16'd1;
         if (expq.size() == 0) begin
            check("unexpected_word", m_data, 32'hDEAD_BEEF);
         end else begin
            e = expq.pop_front();
            check("word_data", w.data, e.data);
            check("word_keep", w.keep, e.keep);
            check("word_last", w.last, e.last);
         end
      end
   endtask

   // One cycle: settle inputs at the falling edge, observe 1 time unit later.
   task automatic tick();
      fifo_empty = (fq.size() == 0) || hold_empty;
      #1;
      monitor();
      @(negedge rclk);
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_m_valid"}, m_valid, 1'b0);
      check({tag, "_m_data"}, m_data, 32'h0);
      check({tag, "_m_keep"}, m_keep, 4'h0);
      check({tag, "_m_last"}, m_last, 1'b0);
      check({tag, "_flush_done"}, flush_done, 1'b0);
      check({tag, "_fifo_r_en"}, fifo_r_en, 1'b0);
   endtask

   task automatic check_got(input string tag, input int idx, input word_t exp_w);
      word_t w;
      w = (idx < got.size()) ? got[idx] : '0;
      check({tag, "_data"}, w.data, exp_w.data);
      check({tag, "_keep"}, w.keep, exp_w.keep);
      check({tag, "_last"}, w.last, exp_w.last);
   endtask

   initial begin
      // Reset values, with the FIFO claiming data available.
      fifo_empty = 1'b0;
      repeat (3) @(negedge rclk);
      #1;
      check_idle_outputs("por");
      @(negedge rclk);
      rrst = 1'b0;
      m_ready = 1'b1;

      // Reset mid-word: 0xAA, 0xBB captured, 0xCC in flight, then reset.
      push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'hDD);
      run(3);
      rrst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      reset_model();
      run(2);
      rrst = 1'b0;
      got.delete();
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      run(12);
      check("midrst_words", got.size(), 1);
      check_got("midrst_w0", 0, '{32'h04030201, 4'hF, 1'b0});

      // Streaming 0x00..0x07 with m_ready high.
      got.delete();
      first_pop_cyc = -1;
      first_valid_cyc = -1;
      for (int i = 0; i < 8; i++) push_byte(8'(i));
      run(14);
      check("stream_latency", first_valid_cyc - first_pop_cyc, 5);
      check("stream_words", got.size(), 2);
      check_got("stream_w0", 0, '{32'h03020100, 4'hF, 1'b0});
      check_got("stream_w1", 1, '{32'h07060504, 4'hF, 1'b0});

      // Backpressure: 12 bytes available, downstream stalled.
      got.delete();
      pops = 0;
      m_ready = 1'b0;
      for (int i = 0; i < 12; i++) push_byte(8'(i));
      run(30);
      check("bp_pops", pops, 8);
      check("bp_r_en", fifo_r_en, 1'b0);
      check("bp_valid", m_valid, 1'b1);
      check("bp_data", m_data, 32'h03020100);
      m_ready = 1'b1;
      run(20);
      check("bp_words", got.size(), 3);
      check_got("bp_w0", 0, '{32'h03020100, 4'hF, 1'b0});
      check_got("bp_w1", 1, '{32'h07060504, 4'hF, 1'b0});
      check_got("bp_w2", 2, '{32'h0B0A0908, 4'hF, 1'b0});

      // Flush of a 3-byte partial word.
      got.delete();
      dones = 0;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      run(8);
      first_valid_cyc = -1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      run(6);
      check("flush_done_lat", done_cyc - flush_cyc, 3);
      check("flush_valid_lat", first_valid_cyc - flush_cyc, 3);
      check("flush_done_pulses", dones, 1);
      check("flush_words", got.size(), 1);
      check_got("flush_w0", 0, '{32'h00332211, 4'b0111, 1'b1});

      // Empty FIFO, then a flush with nothing accumulated.
      got.delete();
      pops = 0;
      dones = 0;
      run(10);
      check("empty_pops", pops, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      run(5);
      check("empty_flush_lat", done_cyc - flush_cyc, 2);
      check("empty_flush_pulses", dones, 1);
      check("empty_flush_words", got.size(), 0);

      // Empty flag held high while data is queued.
      hold_empty = 1'b1;
      push_byte(8'h44); push_byte(8'h55); push_byte(8'h66); push_byte(8'h77);
      run(8);
      check("hold_empty_pops", pops, 0);
      hold_empty = 1'b0;
      run(10);
      check_got("hold_empty_w0", 0, '{32'h77665544, 4'hF, 1'b0});

      // Randomized traffic, backpressure, empty glitches and flushes.
      flushes = 0;
      dones = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0) push_byte(8'($urandom));
         m_ready    = ($urandom_range(0, 3) != 0);
         hold_empty = ($urandom_range(0, 9) == 0);
         flush      = !flush_busy && ($urandom_range(0, 39) == 0);
         tick();
      end
      flush = 1'b0;
      hold_empty = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 200 && fq.size() != 0; i++) tick();
      for (int i = 0; i < 50 && flush_busy; i++) tick();
      check("drain_fifo", fq.size(), 0);
      run(8);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 50 && flush_busy; i++) tick();
      check("drain_flush_done", flush_busy, 1'b0);
      run(5);
      check("drain_expq", expq.size(), 0);
      check("drain_pend", pend.size(), 0);
      check("drain_flush_count", dones, flushes);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
